pll_clk_monitor: RTL and testbench

- Frequency/lock checker for the PLL output domain; the consuming end of the clock generator.
- Runs on the PLL fast clock (199.8 MHz from the 27 MHz board oscillator, ×37/5).
- Samples an asynchronous reference signal, normally the raw 27 MHz oscillator, and counts its rising edges over a fixed window of fast-clock cycles.
- Declares the PLL output good after consecutive in-range windows and flags loss of lock, so downstream LCD/camera logic can gate start-up on `freq_ok`.

---
 rtl/pll_clk_monitor.sv | 157 +++++++++++++++
 tb/tb_pll_clk_monitor.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pll_clk_monitor.sv
`default_nettype none
// ============================================================================
// pll_clk_monitor : counts reference edges per fast-clock window, tracks lock
// Revision 1.0
// ============================================================================
module pll_clk_monitor #(
    parameter int WINDOW       = 2000,
    parameter int EXP_CNT      = 270,
    parameter int TOL          = 4,
    parameter int GOOD_WINDOWS = 4,
    parameter int CNT_W        = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             mon_in,
    input  logic             clr_err,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             meas_valid,
    output logic             freq_ok,
    output logic             err_sticky,
    output logic [1:0]       state
);

    localparam int c_win_w  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int c_good_w = $clog2(GOOD_WINDOWS + 1);
    localparam logic [c_win_w-1:0]  c_win_last = c_win_w'(WINDOW - 1);
    localparam logic [c_good_w-1:0] c_good_max = c_good_w'(GOOD_WINDOWS);
    localparam logic [c_good_w-1:0] c_good_pre = c_good_w'(GOOD_WINDOWS - 1);
    localparam logic [31:0]         c_lo       = 32'(EXP_CNT - TOL);
    localparam logic [31:0]         c_hi       = 32'(EXP_CNT + TOL);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ACQUIRE = 2'b01,
        ST_LOCKED  = 2'b10
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_s1, r_s2, r_s3;
    logic [c_win_w-1:0]  r_win_cnt;
    logic [CNT_W-1:0]    r_edge_cnt;
    logic [CNT_W-1:0]    r_meas_cnt;
    logic                r_meas_valid;
    logic                r_freq_ok, w_freq_nxt;
    logic                r_err;
    logic [c_good_w-1:0] r_good_run, w_good_nxt;
    logic                w_err_set;
    logic                w_edge;
    logic                w_active;
    logic                w_close;
    logic [CNT_W:0]      w_sum;
    logic [CNT_W-1:0]    w_sum_sat;
    logic                w_in_range;

    assign w_edge     = r_s2 & ~r_s3;
    assign w_active   = enable && (r_state != ST_IDLE);
    assign w_close    = w_active && (r_win_cnt == c_win_last);
    assign w_sum      = {1'b0, r_edge_cnt} + {{CNT_W{1'b0}}, w_edge};
    // Carry out means the counter was already at full scale: hold it there
    assign w_sum_sat  = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    assign w_in_range = (32'(w_sum_sat) >= c_lo) && (32'(w_sum_sat) <= c_hi);

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_run;
        w_freq_nxt  = r_freq_ok;
        w_err_set   = 1'b0;
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_good_nxt  = '0;
            w_freq_nxt  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_ACQUIRE;
                ST_ACQUIRE: begin
                    if (w_close) begin
                        if (w_in_range) begin
                            w_good_nxt = (r_good_run >= c_good_pre) ? c_good_max
                                                                    : r_good_run + 1'b1;
                            if (w_good_nxt == c_good_max) begin
                                w_state_nxt = ST_LOCKED;
                                w_freq_nxt  = 1'b1;
                            end
                        end else begin
                            w_good_nxt = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_close && !w_in_range) begin
                        w_state_nxt = ST_ACQUIRE;
                        w_good_nxt  = '0;
                        w_freq_nxt  = 1'b0;
                        w_err_set   = 1'b1;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_good_run <= '0;
            r_freq_ok  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_run <= w_good_nxt;
            r_freq_ok  <= w_freq_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            r_win_cnt    <= '0;
            r_edge_cnt   <= '0;
            r_meas_cnt   <= '0;
            r_meas_valid <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_s1         <= mon_in;
            r_s2         <= r_s1;
            r_s3         <= r_s2;
            r_meas_valid <= w_close;
            if (!w_active) begin
                r_win_cnt  <= '0;
                r_edge_cnt <= '0;
            end else if (w_close) begin
                r_win_cnt  <= '0;
                r_edge_cnt <= '0;
                r_meas_cnt <= w_sum_sat;
            end else begin
                r_win_cnt  <= r_win_cnt + 1'b1;
                r_edge_cnt <= w_sum_sat;
            end
            // A loss-of-lock event takes priority over a clear in the same cycle
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (clr_err) begin
                r_err <= 1'b0;
            end
        end
    end

    assign meas_cnt   = r_meas_cnt;
    assign meas_valid = r_meas_valid;
    assign freq_ok    = r_freq_ok;
    assign err_sticky = r_err;
    assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pll_clk_monitor.sv
`timescale 1ps/1ps
`default_nettype none
// tb_pll_clk_monitor : directed bench for the PLL frequency/lock monitor
module tb_pll_clk_monitor;

    logic        clk;
    logic        rst_n    = 1'b0;
    logic        enable   = 1'b0;
    logic        clr_err  = 1'b0;
    logic        mon_gen  = 1'b0;
    logic        mon_stop = 1'b0;
    logic        mon_in;
    logic        enable_s = 1'b0;
    logic        mon_sat  = 1'b0;
    logic        sat_run  = 1'b0;
    int          mon_hi   = 18518;
    int          mon_lo   = 18519;

    logic [11:0] meas_cnt;
    logic        meas_valid, freq_ok, err_sticky;
    logic [1:0]  state;
    logic [5:0]  meas_cnt_s;
    logic        meas_valid_s, freq_ok_s, err_sticky_s;
    logic [1:0]  state_s;

    int n_checks = 0;
    int n_fail   = 0;

    pll_clk_monitor dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .mon_in(mon_in), .clr_err(clr_err),
        .meas_cnt(meas_cnt), .meas_valid(meas_valid), .freq_ok(freq_ok),
        .err_sticky(err_sticky), .state(state)
    );

    pll_clk_monitor #(.CNT_W(6)) dut_sat (
        .clk(clk), .rst_n(rst_n), .enable(enable_s), .mon_in(mon_sat), .clr_err(1'b0),
        .meas_cnt(meas_cnt_s), .meas_valid(meas_valid_s), .freq_ok(freq_ok_s),
        .err_sticky(err_sticky_s), .state(state_s)
    );

    // 5.005 ns fast clock
    always begin
        clk = 1'b0; #2503;
        clk = 1'b1; #2502;
    end

    always begin
        mon_gen = 1'b1; #(mon_hi);
        mon_gen = 1'b0; #(mon_lo);
    end
    assign mon_in = mon_gen & ~mon_stop;

    always @(negedge clk) if (sat_run) mon_sat = ~mon_sat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_valid(input bit sat, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!(sat ? meas_valid_s : meas_valid) && cyc < budget);
        check("valid_seen", {31'b0, (sat ? meas_valid_s : meas_valid)}, 32'd1);
    endtask

    function automatic bit in_rng(input logic [31:0] v, input int lo, input int hi);
        return (v >= 32'(lo)) && (v <= 32'(hi));
    endfunction

    initial begin
        int          cyc;
        bit          any_v;
        logic [11:0] held;

        tick(3);
        check("rst_meas_cnt", meas_cnt, 0);
        check("rst_meas_valid", meas_valid, 0);
        check("rst_freq_ok", freq_ok, 0);
        check("rst_err", err_sticky, 0);
        check("rst_state", state, 0);
        check("rst_sat_cnt", meas_cnt_s, 0);
        check("rst_sat_state", state_s, 0);

        // Nominal lock-in
        enable = 1'b1;
        rst_n  = 1'b1;
        wait_valid(0, 2100, cyc);
        check("first_latency", cyc, 2001);
        check("nom_cnt0", in_rng(meas_cnt, 270, 271), 1);
        check("nom_freq0", freq_ok, 0);
        check("nom_state0", state, 1);
        for (int i = 1; i <= 3; i++) begin
            wait_valid(0, 2100, cyc);
            check("nom_period", cyc, 2000);
            check("nom_cnt", in_rng(meas_cnt, 270, 271), 1);
            check("nom_freq", freq_ok, (i == 3) ? 1 : 0);
            check("nom_state", state, (i == 3) ? 2 : 1);
            check("nom_err", err_sticky, 0);
        end

        // Loss of lock, with clr_err asserted on the setting cycle
        tick(1995);
        mon_stop = 1'b1;
        wait_valid(0, 10, cyc);
        check("lol_pre_lat", cyc, 5);
        check("lol_pre_cnt", in_rng(meas_cnt, 266, 274), 1);
        check("lol_pre_freq", freq_ok, 1);
        tick(1999);
        clr_err = 1'b1;
        wait_valid(0, 2, cyc);
        clr_err  = 1'b0;
        mon_stop = 1'b0;
        check("lol_lat", cyc, 1);
        check("lol_cnt", meas_cnt, 0);
        check("lol_freq", freq_ok, 0);
        check("lol_err_set_wins", err_sticky, 1);
        check("lol_state", state, 1);
        tick(2);
        check("err_retained", err_sticky, 1);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("err_cleared", err_sticky, 0);

        // Relock
        for (int i = 0; i < 6 && !freq_ok; i++) wait_valid(0, 2100, cyc);
        check("relock_freq", freq_ok, 1);
        check("relock_state", state, 2);
        check("relock_err", err_sticky, 0);

        // Enable drop at window count 1000
        tick(1000);
        held = meas_cnt;
        check("held_cnt", in_rng(held, 266, 274), 1);
        enable = 1'b0;
        tick(1);
        check("drop_valid", meas_valid, 0);
        check("drop_state", state, 0);
        check("drop_freq", freq_ok, 0);
        any_v = 1'b0;
        repeat (2100) begin
            tick(1);
            any_v |= meas_valid;
        end
        check("drop_no_valid", any_v, 0);
        check("drop_cnt_kept", meas_cnt, held);
        enable = 1'b1;
        tick(1);
        check("reen_state", state, 1);
        wait_valid(0, 2100, cyc);
        check("reen_latency", cyc, 2000);
        check("reen_cnt", in_rng(meas_cnt, 270, 271), 1);
        check("reen_freq", freq_ok, 0);

        // Wrong ratio: 33.3 MHz reference
        mon_hi = 15030;
        mon_lo = 15030;
        wait_valid(0, 2100, cyc);
        for (int i = 0; i < 2; i++) begin
            wait_valid(0, 2100, cyc);
            check("wr_period", cyc, 2000);
            check("wr_cnt", in_rng(meas_cnt, 333, 334), 1);
            check("wr_freq", freq_ok, 0);
            check("wr_state", state, 1);
            check("wr_err", err_sticky, 0);
        end

        // Asynchronous reset mid-window
        tick(1500);
        #100;
        rst_n = 1'b0;
        #1;
        check("arst_cnt", meas_cnt, 0);
        check("arst_valid", meas_valid, 0);
        check("arst_freq", freq_ok, 0);
        check("arst_err", err_sticky, 0);
        check("arst_state", state, 0);
        tick(2);
        rst_n = 1'b1;
        wait_valid(0, 2100, cyc);
        check("arst_latency", cyc, 2001);
        check("arst_cnt_after", in_rng(meas_cnt, 333, 334), 1);
        check("arst_state_after", state, 1);

        // Saturation with a 6-bit counter and reference at clk/2
        sat_run  = 1'b1;
        enable_s = 1'b1;
        wait_valid(1, 2100, cyc);
        check("sat_latency", cyc, 2001);
        check("sat_cnt", meas_cnt_s, 63);
        check("sat_freq", freq_ok_s, 0);
        check("sat_state", state_s, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
